// File: rtl/mem_if_pkg.sv
// Shared encodings for the ALU data-memory port and its responder FSM.
package mem_if_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_RSVD  = 2'd3
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM: write-enable, registered read.
module mem_responder_ram
   import mem_if_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic                 i_re,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   output logic [DATA_W-1:0]    o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_addr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// ALU data-memory responder: latches a request, waits, then acknowledges
// with a four-phase handshake and drives DataIO only for read data.
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MemIO,
   input  logic [31:0]       ALUAddr,
   inout  wire  [DATA_W-1:0] DataIO,
   output logic              ValidMemData,
   output logic              AddrError,
   output logic              Busy
);

   mem_state_e             r_state;
   mem_op_e                r_op;
   logic [3:0]             r_cnt;
   logic [ADDR_BITS-1:0]   r_idx;
   logic                   r_oor;
   logic [DATA_W-1:0]      r_wdata;
   logic                   r_valid;
   logic                   r_err;

   logic                   w_oor_in;
   logic                   w_enter;
   logic                   w_we;
   logic                   w_re;
   logic                   w_drive;
   logic [DATA_W-1:0]      w_rdata;

   assign w_oor_in = (ALUAddr >= 32'(DEPTH));

   // RAM is touched only on the edge that enters RESP; reset on
   // that same edge wins so an abandoned write never commits.
   assign w_enter = (r_state == ST_WAIT) && (r_cnt == 4'd0)
                 && (MemIO != MEM_IDLE) && !rst;
   assign w_we    = w_enter && (r_op == MEM_WRITE) && !r_oor;
   assign w_re    = w_enter && (r_op == MEM_READ) && !r_oor;

   mem_responder_ram #(
      .DEPTH     (DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= MEM_IDLE;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (MemIO != MEM_IDLE) begin
                  r_op    <= mem_op_e'(MemIO);
                  r_idx   <= ALUAddr[ADDR_BITS-1:0];
                  r_oor   <= w_oor_in;
                  r_wdata <= DataIO;
                  r_cnt   <= 4'(WAIT_STATES);
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (MemIO == MEM_IDLE) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
                  r_valid <= 1'b1;
                  r_err   <= r_oor || (r_op == MEM_RSVD);
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (MemIO == MEM_IDLE) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Release the bus as soon as the ALU drops its read request.
   assign w_drive = (r_state == ST_RESP) && (r_op == MEM_READ)
                 && (MemIO == MEM_READ);

   assign DataIO       = w_drive ? (r_oor ? '0 : w_rdata) : 'z;
   assign ValidMemData = r_valid;
   assign AddrError    = r_err;
   assign Busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder at WAIT_STATES=2 and 0, checked
// every cycle against a transaction-level model of the handshake.
module tb_mem_responder;
   import mem_if_pkg::*;

   localparam int          DEPTH = 256;
   localparam logic [31:0] UNDR  = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit done [2];

   function automatic void cmp(string nm, logic [31:0] act,
                               logic [31:0] exp, int g);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ws_inst%0d t=%0t got %h expected %h",
                  nm, g, $time, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int WS = (g == 0) ? 2 : 0;

      logic        rst;
      logic [1:0]  memio;
      logic [31:0] addr;
      wire  [31:0] bus;
      logic        valid, aerr, busy;
      logic        tb_oe;
      logic [31:0] tb_d;
      logic        chk;
      logic        e_valid, e_err, e_busy;
      logic [31:0] e_bus;
      logic [31:0] mem [DEPTH];
      int          lat;
      logic [31:0] got;

      assign bus = tb_oe ? tb_d : 'z;
      for (genvar b = 0; b < 32; b++) begin : g_pu
         pullup (bus[b]);
      end

      mem_responder #(
         .DEPTH       (DEPTH),
         .ADDR_BITS   (8),
         .WAIT_STATES (WS)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .MemIO        (memio),
         .ALUAddr      (addr),
         .DataIO       (bus),
         .ValidMemData (valid),
         .AddrError    (aerr),
         .Busy         (busy)
      );

      always @(negedge clk) begin
         if (chk === 1'b1) begin
            cmp("valid", 32'(valid), 32'(e_valid), g);
            cmp("aerr", 32'(aerr), 32'(e_err), g);
            cmp("busy", 32'(busy), 32'(e_busy), g);
            cmp("dataio", bus, e_bus, g);
         end
      end

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      task automatic idle_exp();
         e_valid = 1'b0;
         e_err   = 1'b0;
         e_busy  = 1'b0;
         e_bus   = UNDR;
      endtask

      // n_on: edges that sample MemIO!=0 (first is the request edge).
      // rst_edge: edge index that samples rst=1, or -1 for none.
      task automatic req(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int n_on,
                         input int rst_edge);
         logic [31:0] rv;
         bit          inr;
         inr = (a < DEPTH);
         rv  = inr ? mem[a[7:0]] : 32'h0;
         lat = -1;
         got = UNDR;
         memio = op;
         addr  = a;
         tb_d  = d;
         tb_oe = (op == MEM_WRITE);
         rst   = (rst_edge == 0);
         idle_exp();
         if (tb_oe) e_bus = d;
         for (int j = 0; j <= n_on; j++) begin
            bit rsd, ack, nxt;
            step();
            rsd = (rst_edge >= 0) && (j >= rst_edge);
            ack = !rsd && (j < n_on) && (j >= 1 + WS);
            nxt = (j + 1 < n_on);
            if (valid === 1'b1 && lat < 0) lat = j;
            if (ack && op == MEM_READ && nxt) got = bus;
            if (ack && j == 1 + WS && op == MEM_WRITE && inr)
               mem[a[7:0]] = d;
            memio   = nxt ? op : 2'd0;
            rst     = (rst_edge >= 0) && (j + 1 == rst_edge);
            tb_oe   = nxt && (op == MEM_WRITE);
            e_valid = ack;
            e_err   = ack && (op == MEM_RSVD || !inr);
            e_busy  = !rsd && (j < n_on);
            if (tb_oe)
               e_bus = d;
            else if (ack && op == MEM_READ && nxt)
               e_bus = rv;
            else
               e_bus = UNDR;
         end
      endtask

      initial begin
         chk   = 1'b0;
         rst   = 1'b1;
         memio = 2'd0;
         addr  = 32'd0;
         tb_oe = 1'b0;
         tb_d  = 32'd0;
         got   = UNDR;
         idle_exp();
         repeat (3) step();
         chk = 1'b1;
         rst = 1'b0;
         step();
         cmp("rst_valid", 32'(valid), 32'd0, g);
         cmp("rst_busy", 32'(busy), 32'd0, g);
         cmp("rst_bus", bus, UNDR, g);

         for (int i = 0; i < 16; i++)
            req(MEM_WRITE, 32'(i), $urandom, WS + 2, -1);
         req(MEM_WRITE, 32'd44, $urandom, WS + 2, -1);

         req(MEM_WRITE, 32'd5, 32'hDEAD_BEEF, WS + 2, -1);
         cmp("wr5_lat", 32'(lat), (g == 0) ? 32'd3 : 32'd1, g);
         req(MEM_READ, 32'd5, 32'd0, WS + 2 + 5, -1);
         cmp("rd5_lat", 32'(lat), (g == 0) ? 32'd3 : 32'd1, g);
         cmp("rd5_data", got, 32'hDEAD_BEEF, g);

         req(MEM_READ, 32'd300, 32'd0, WS + 3, -1);
         cmp("oor_data", got, 32'd0, g);
         req(MEM_WRITE, 32'd300, 32'h0000_1234, WS + 2, -1);
         req(MEM_READ, 32'd44, 32'd0, WS + 3, -1);
         cmp("alias44", got, mem[44], g);

         req(MEM_WRITE, 32'd7, $urandom, WS + 1, -1);
         cmp("abort_lat", 32'(lat), 32'hFFFF_FFFF, g);
         req(MEM_READ, 32'd7, 32'd0, WS + 3, -1);

         req(MEM_WRITE, 32'd9, $urandom, 2, 1);
         cmp("rst_wr_lat", 32'(lat), 32'hFFFF_FFFF, g);
         req(MEM_READ, 32'd9, 32'd0, WS + 3, -1);

         req(MEM_RSVD, 32'd3, 32'd0, WS + 3, -1);
         cmp("rsvd_lat", 32'(lat), (g == 0) ? 32'd3 : 32'd1, g);

         for (int i = 0; i < 200; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            int          kind, r;
            op = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) < 8)
               a = 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 1)
               a = 32'($urandom_range(256, 400));
            else
               a = 32'hFFFF_FF00 | 32'($urandom_range(0, 15));
            kind = $urandom_range(0, 19);
            if (kind < 2) begin
               r = $urandom_range(1, WS + 3);
               req(op, a, $urandom, r + 1, r);
            end else if (kind < 4) begin
               req(op, a, $urandom, $urandom_range(1, WS + 1), -1);
            end else begin
               req(op, a, $urandom, WS + 2 + $urandom_range(0, 3), -1);
            end
         end
         step();
         done[g] = 1'b1;
      end
   end

   initial begin
      for (int c = 0; c < 50000 && !(done[0] && done[1]); c++)
         @(posedge clk);
      if (!(done[0] && done[1])) begin
         checks++;
         errors++;
         $display("FAIL timeout: stimulus did not complete");
      end
      #20;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
